// File: rtl/sram_pkg.sv
// sram_pkg: supply/threshold levels, access FSM state type and logic<->level helpers
package sram_pkg;
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;
  typedef enum logic [2:0] {IDLE, PRECH, ACCESS, SENSE, RESP} acc_state_t;
  function automatic real lvl(input logic b);
    return b ? VDD : VSS;
  endfunction
  function automatic logic thr(input real v);
    return v >= VTH;
  endfunction
endpackage

// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: valid/ready request (we/addr/wdata) and response (rdata) bus
interface sram_access_ctrl_if #(parameter int ADDR_W = 3, parameter int COLS = 8);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [COLS-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [COLS-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_wl_decoder.sv
// sram_wl_decoder: addr_i/en_i to one-hot real wordlines wl_o; addresses >= ROWS select none
module sram_wl_decoder import sram_pkg::*; #(
  parameter int ROWS = 8,
  parameter int ADDR_W = 3
) (
  input logic [ADDR_W-1:0] addr_i,
  input logic en_i,
  output real wl_o [0:ROWS-1]
);
  always_comb
    for (int r = 0; r < ROWS; r++) wl_o[r] = lvl(en_i && addr_i == ADDR_W'(r));
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: SRAM read/write sequencer (clk, rst, bus slave; real rd_wr/wl/we_drv/wr_bl/sae out, sa_out in)
module sram_access_ctrl import sram_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int PRE_CYC = 2,
  parameter int ACC_CYC = 2
) (
  input logic clk,
  input logic rst,
  sram_access_ctrl_if.slave bus,
  output real rd_wr,
  output real wl [0:ROWS-1],
  output real we_drv,
  output real wr_bl [0:COLS-1],
  output real sae,
  input real sa_out [0:COLS-1]
);
  localparam int ADDR_W = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int MAX_CYC = PRE_CYC > ACC_CYC ? PRE_CYC : ACC_CYC;
  localparam int CNT_W = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
  acc_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COLS-1:0] wdata_q;
  logic [COLS-1:0] rdata_q;
  logic [COLS-1:0] sense_d;
  logic write_phase;
  assign bus.req_ready = state_q == IDLE && !rst;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign write_phase = state_q == ACCESS && we_q;
  sram_wl_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_dec (
    .addr_i(addr_q),
    .en_i(state_q == ACCESS || state_q == SENSE),
    .wl_o(wl)
  );
  always_comb begin
    rd_wr = lvl(!write_phase);
    we_drv = lvl(write_phase);
    sae = lvl(state_q == SENSE);
    for (int i = 0; i < COLS; i++) begin
      wr_bl[i] = lvl(write_phase && wdata_q[i]);
      sense_d[i] = thr(sa_out[i]) && int'(addr_q) < ROWS;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q <= PRECH;
          cnt_q <= CNT_W'(PRE_CYC - 1);
          we_q <= bus.req_we;
          addr_q <= bus.req_addr;
          wdata_q <= bus.req_wdata;
        end
        PRECH: begin
          state_q <= cnt_q == '0 ? ACCESS : PRECH;
          cnt_q <= cnt_q == '0 ? CNT_W'(ACC_CYC - 1) : cnt_q - CNT_W'(1);
        end
        ACCESS: if (cnt_q == '0) begin
          state_q <= we_q ? RESP : SENSE;
          rdata_q <= '0;
        end else cnt_q <= cnt_q - CNT_W'(1);
        SENSE: begin
          state_q <= RESP;
          rdata_q <= sense_d;
        end
        RESP: if (bus.rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: randomized scoreboard bench for sram_access_ctrl against a behavioural SRAM macro
module tb_sram_access_ctrl;
  localparam int P = 2;
  localparam int A = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sram_access_ctrl_if #(.ADDR_W(3), .COLS(8)) bus ();
  sram_access_ctrl_if #(.ADDR_W(3), .COLS(8)) bus2 ();
  real rd_wr, we_drv, sae, rd_wr2, we_drv2, sae2;
  real wl [0:7];
  real wr_bl [0:7];
  real sa_out [0:7];
  real wl2 [0:5];
  real wr_bl2 [0:7];
  real sa_out2 [0:7];
  real hi_tab [3] = '{0.8, 1.0, 1.5};
  real lo_tab [3] = '{0.0, 0.5, 0.79};
  real thr_tab [4] = '{0.79, 0.80, 1.5, 0.0};
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model_mem [8];
  logic [7:0] store [8];
  bit thr_mode = 1'b0;
  sram_access_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_wr(rd_wr), .wl(wl), .we_drv(we_drv),
    .wr_bl(wr_bl), .sae(sae), .sa_out(sa_out)
  );
  sram_access_ctrl #(.ROWS(6), .COLS(8), .PRE_CYC(1), .ACC_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .rd_wr(rd_wr2), .wl(wl2), .we_drv(we_drv2),
    .wr_bl(wr_bl2), .sae(sae2), .sa_out(sa_out2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask
  function automatic logic enc(input real v);
    return v == 1.5 ? 1'b1 : v == 0.0 ? 1'b0 : 1'bx;
  endfunction
  function automatic logic [20:0] mk(input logic rv, rr, rdwr, wed, sa, input logic [7:0] w, b);
    return {rv, rr, rdwr, wed, sa, w, b};
  endfunction
  function automatic logic [20:0] obs1();
    logic [7:0] w, b;
    for (int i = 0; i < 8; i++) begin
      w[i] = enc(wl[i]);
      b[i] = enc(wr_bl[i]);
    end
    return mk(bus.rsp_valid, bus.req_ready, enc(rd_wr), enc(we_drv), enc(sae), w, b);
  endfunction
  always @(negedge clk) begin
    int r;
    logic b;
    r = -1;
    for (int i = 0; i < 8; i++) if (wl[i] >= 0.8) r = i;
    if (we_drv >= 0.8 && r >= 0) for (int i = 0; i < 8; i++) store[r][i] = wr_bl[i] >= 0.8;
    for (int i = 0; i < 8; i++) begin
      b = (sae >= 0.8 && r >= 0) ? store[r][i] : 1'($urandom_range(0, 1));
      sa_out[i] = thr_mode ? thr_tab[i % 4] : b ? hi_tab[$urandom_range(0, 2)] : lo_tab[$urandom_range(0, 2)];
    end
  end
  bit act = 1'b0;
  bit pend = 1'b0;
  bit rst_prev = 1'b1;
  bit m_we;
  logic [2:0] m_a;
  logic [7:0] m_d;
  int n;
  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) chk("reset_state", 32'(obs1()), 32'(mk(0, 0, 1, 0, 0, 8'h00, 8'h00)));
      act = 1'b0;
      pend = 1'b0;
      exp_q.delete();
    end else begin
      if (pend) begin
        act = 1'b1;
        n = 0;
      end
      pend = 1'b0;
      if (!act) begin
        chk("idle_state", 32'(obs1()), 32'(mk(0, 1, 1, 0, 0, 8'h00, 8'h00)));
        if (bus.req_valid) begin
          pend = 1'b1;
          m_we = bus.req_we;
          m_a = bus.req_addr;
          m_d = bus.req_wdata;
        end
      end else begin
        n++;
        if (n <= P)
          chk("prech", 32'(obs1()), 32'(mk(0, 0, 1, 0, 0, 8'h00, 8'h00)));
        else if (n <= P + A)
          chk("access", 32'(obs1()), 32'(mk(0, 0, !m_we, m_we, 0, 8'h01 << m_a, m_we ? m_d : 8'h00)));
        else if (!m_we && n == P + A + 1)
          chk("sense", 32'(obs1()), 32'(mk(0, 0, 1, 0, 1, 8'h01 << m_a, 8'h00)));
        else begin
          chk("resp", 32'(obs1()), 32'(mk(1, 0, 1, 0, 0, 8'h00, 8'h00)));
          if (exp_q.size() == 0) timeout("resp_unexpected");
          else begin
            chk("rdata", 32'(bus.rsp_rdata), 32'(exp_q[0]));
            if (bus.rsp_ready) begin
              void'(exp_q.pop_front());
              act = 1'b0;
            end
          end
        end
      end
    end
    rst_prev = rst;
  end
  task automatic set_req(input bit we, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    if (we) begin
      model_mem[a] = d;
      exp_q.push_back(8'h00);
    end else exp_q.push_back(thr_mode ? 8'h66 : model_mem[a]);
  endtask
  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else timeout("accept");
  endtask
  task automatic finish_rsp(input int hold);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    if (!got) timeout("response");
    else begin
      repeat (hold + 1) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
    end
  endtask
  task automatic op(input bit we, input logic [2:0] a, input logic [7:0] d, input int hold);
    set_req(we, a, d);
    wait_accept();
    bus.req_valid = 1'b0;
    finish_rsp(hold);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end
  initial begin
    bit we;
    logic [2:0] a;
    logic [7:0] d;
    int first;
    logic [5:0] w2;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus2.req_valid = 1'b0;
    bus2.req_we = 1'b0;
    bus2.req_addr = '0;
    bus2.req_wdata = '0;
    bus2.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'h00;
      store[i] = 8'h00;
      sa_out2[i] = 1.5;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op(1'b1, 3'd3, 8'hA5, 0);
    op(1'b0, 3'd3, 8'h00, 0);
    thr_mode = 1'b1;
    op(1'b0, 3'd5, 8'h00, 1);
    thr_mode = 1'b0;
    set_req(1'b1, 3'd6, 8'h3C);
    wait_accept();
    set_req(1'b0, 3'd6, 8'h00);
    finish_rsp(4);
    wait_accept();
    bus.req_valid = 1'b0;
    finish_rsp(0);
    set_req(1'b1, 3'd2, model_mem[2]);
    wait_accept();
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      thr_mode = !we && $urandom_range(0, 7) == 0;
      op(we, a, d, $urandom_range(0, 3));
      thr_mode = 1'b0;
    end
    bus2.req_valid = 1'b1;
    bus2.req_we = 1'b0;
    bus2.req_addr = 3'd7;
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      @(negedge clk);
      if (bus2.req_ready) first = 0;
    end
    if (first < 0) timeout("ovr_accept");
    else begin
      @(posedge clk);
      #1 bus2.req_valid = 1'b0;
      for (int c = 1; c <= 12 && first == 0; c++) begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) w2[i] = enc(wl2[i]);
        chk("ovr_wl", 32'(w2), 32'd0);
        chk("ovr_sae", 32'(enc(sae2)), 32'(c == 5));
        if (bus2.rsp_valid) first = c;
      end
      chk("ovr_latency", 32'(first), 32'd6);
      chk("ovr_rdata", 32'(bus2.rsp_rdata), 32'd0);
      @(posedge clk);
      #1 bus2.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus2.rsp_ready = 1'b0;
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
